decodificador_pt2272: RTL and testbench

DECODIFICADOR_PT2272 -- requirements
Module: decodificador_pt2272

---
 rtl/decodificador_pt2272.sv | 279 +++++++++++++++++++++++++++
 tb/tb_decodificador_pt2272.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/decodificador_pt2272.sv
// PT2272-style receiver for PT2262 frames.
// Samples the line on a prescaled tick, measures level widths, decodes
// 12 tri-state symbols per frame and raises vt after two identical frames
// whose address symbols all match A.
// Optional build macro: DECOD_MOMENTARY_EN clears D when vt drops.
// Without it, D keeps the last accepted value.
module decodificador_pt2272 #(
    parameter int unsigned PRESC      = 250,
    parameter int unsigned SYNC_MIN   = 80,
    parameter int unsigned VT_TIMEOUT = 1100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cod_i,
    input  logic [15:0] A,
    output logic [3:0]  D,
    output logic        vt,
    output logic        sync_det
);

    localparam int unsigned TW  = (PRESC > 2) ? $clog2(PRESC) : 1;
    localparam int unsigned TOW = $clog2(VT_TIMEOUT + 1);

    typedef enum logic [2:0] {
        WAIT_SYNC,
        SYNC_LOW,
        RX_H1,
        RX_L1,
        RX_H2,
        RX_L2,
        END_H,
        END_LOW
    } state_t;

    state_t         state_q, state_d;
    logic           sync1_q, sync1_d, sync2_q, sync2_d;
    logic [TW-1:0]  tick_cnt_q, tick_cnt_d;
    logic           lvl_q, lvl_d;
    logic [7:0]     wid_q, wid_d;
    logic           synced_q, synced_d;
    logic [3:0]     idx_q, idx_d;
    logic           h1_q, h1_d, l1_q, l1_d, h2_q, h2_d;
    logic           addr_ok_q, addr_ok_d;
    logic [3:0]     data_q, data_d;
    logic           prev_valid_q, prev_valid_d;
    logic [3:0]     prev_data_q, prev_data_d;
    logic [TOW-1:0] to_q, to_d;
    logic           vt_q, vt_d;
    logic [3:0]     d_q, d_d;
    logic           sync_det_q, sync_det_d;

    logic           tick, changed, fall, rise, low_reach;
    logic           is_short, is_long;
    logic [1:0]     sym_code;
    logic           sym_err, abort, close, accept;

    // Synchronizer, sample tick and level-width measurement
    always_comb begin
        sync1_d    = cod_i;
        sync2_d    = sync1_q;
        tick       = (tick_cnt_q == TW'(PRESC - 1));
        tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
        changed    = tick && (sync2_q != lvl_q);
        fall       = changed && lvl_q;
        rise       = changed && !lvl_q;
        // Low level reaches SYNC_MIN on this tick (counter about to step onto it)
        low_reach  = tick && !changed && !lvl_q && (wid_q == 8'(SYNC_MIN - 1));
        lvl_d      = lvl_q;
        wid_d      = wid_q;
        if (changed) begin
            lvl_d = sync2_q;
            wid_d = 8'd1;
        end else if (tick && (wid_q != 8'hFF)) begin
            wid_d = wid_q + 8'd1;
        end
        is_short = (wid_q >= 8'd2) && (wid_q <= 8'd6);
        is_long  = (wid_q >= 8'd9) && (wid_q <= 8'd15);
    end

    // Frame FSM, symbol decode, frame compare and vt timeout
    always_comb begin
        state_d      = state_q;
        synced_d     = synced_q;
        idx_d        = idx_q;
        h1_d         = h1_q;
        l1_d         = l1_q;
        h2_d         = h2_q;
        addr_ok_d    = addr_ok_q;
        data_d       = data_q;
        prev_valid_d = prev_valid_q;
        prev_data_d  = prev_data_q;
        to_d         = to_q;
        vt_d         = vt_q;
        d_d          = d_q;
        sync_det_d   = 1'b0;
        abort        = 1'b0;
        close        = 1'b0;
        accept       = 1'b0;
        sym_code     = 2'b00;
        sym_err      = 1'b0;

        // Pattern H1 L1 H2 L2 as long-flags; L2 is the width closing now
        case ({h1_q, l1_q, h2_q, is_long})
            4'b0101: sym_code = 2'b00;
            4'b1010: sym_code = 2'b11;
            4'b0110: sym_code = 2'b01;
            default: sym_err  = 1'b1;
        endcase

        case (state_q)
            WAIT_SYNC: begin
                if (fall && is_short) begin
                    state_d  = SYNC_LOW;
                    synced_d = 1'b0;
                end
            end
            SYNC_LOW: begin
                if (low_reach && !synced_q) begin
                    sync_det_d = 1'b1;
                    synced_d   = 1'b1;
                end else if (rise) begin
                    if (synced_q) begin
                        state_d   = RX_H1;
                        idx_d     = 4'd0;
                        addr_ok_d = 1'b1;
                        data_d    = 4'd0;
                    end else begin
                        abort = 1'b1;
                    end
                end
            end
            RX_H1: begin
                if (fall) begin
                    if (is_short || is_long) begin
                        h1_d    = is_long;
                        state_d = RX_L1;
                    end else begin
                        abort = 1'b1;
                    end
                end
            end
            RX_L1: begin
                if (rise) begin
                    if (is_short || is_long) begin
                        l1_d    = is_long;
                        state_d = RX_H2;
                    end else begin
                        abort = 1'b1;
                    end
                end
            end
            RX_H2: begin
                if (fall) begin
                    if (is_short || is_long) begin
                        h2_d    = is_long;
                        state_d = RX_L2;
                    end else begin
                        abort = 1'b1;
                    end
                end
            end
            RX_L2: begin
                if (rise) begin
                    if (sym_err || !(is_short || is_long)) begin
                        abort = 1'b1;
                    end else if (idx_q < 4'd8) begin
                        addr_ok_d = addr_ok_q && (sym_code == A[{idx_q[2:0], 1'b0} +: 2]);
                    end else if (sym_code == 2'b01) begin
                        abort = 1'b1;
                    end else begin
                        data_d = {data_q[2:0], sym_code[1]};
                    end
                    if (!abort) begin
                        idx_d   = idx_q + 4'd1;
                        state_d = (idx_q == 4'd11) ? END_H : RX_H1;
                    end
                end
            end
            END_H: begin
                if (fall) begin
                    if (is_short) begin
                        state_d = END_LOW;
                    end else begin
                        abort = 1'b1;
                    end
                end
            end
            END_LOW: begin
                if (low_reach) begin
                    sync_det_d = 1'b1;
                    close      = 1'b1;
                    synced_d   = 1'b1;
                    state_d    = SYNC_LOW;
                end else if (rise) begin
                    abort = 1'b1;
                end
            end
            default: state_d = WAIT_SYNC;
        endcase

        // Expiry first so an abort or a closing frame on the same tick still applies
        if (tick && (to_q != '0)) begin
            to_d = to_q - TOW'(1);
            if (to_q == TOW'(1)) begin
                vt_d         = 1'b0;
                prev_valid_d = 1'b0;
`ifdef DECOD_MOMENTARY_EN
                d_d          = '0;
`endif
            end
        end

        if (abort) begin
            state_d      = WAIT_SYNC;
            prev_valid_d = 1'b0;
        end

        if (close) begin
            accept       = addr_ok_q && prev_valid_q && (prev_data_q == data_q);
            prev_valid_d = addr_ok_q;
            prev_data_d  = addr_ok_q ? data_q : prev_data_q;
            if (accept) begin
                vt_d = 1'b1;
                d_d  = data_q;
                to_d = TOW'(VT_TIMEOUT);
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= WAIT_SYNC;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            tick_cnt_q   <= '0;
            lvl_q        <= 1'b0;
            wid_q        <= '0;
            synced_q     <= 1'b0;
            idx_q        <= '0;
            h1_q         <= 1'b0;
            l1_q         <= 1'b0;
            h2_q         <= 1'b0;
            addr_ok_q    <= 1'b0;
            data_q       <= '0;
            prev_valid_q <= 1'b0;
            prev_data_q  <= '0;
            to_q         <= '0;
            vt_q         <= 1'b0;
            d_q          <= '0;
            sync_det_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            tick_cnt_q   <= tick_cnt_d;
            lvl_q        <= lvl_d;
            wid_q        <= wid_d;
            synced_q     <= synced_d;
            idx_q        <= idx_d;
            h1_q         <= h1_d;
            l1_q         <= l1_d;
            h2_q         <= h2_d;
            addr_ok_q    <= addr_ok_d;
            data_q       <= data_d;
            prev_valid_q <= prev_valid_d;
            prev_data_q  <= prev_data_d;
            to_q         <= to_d;
            vt_q         <= vt_d;
            d_q          <= d_d;
            sync_det_q   <= sync_det_d;
        end
    end

    assign D        = d_q;
    assign vt       = vt_q;
    assign sync_det = sync_det_q;

endmodule

// File: tb/tb_decodificador_pt2272.sv
// Directed bench for decodificador_pt2272: builds PT2262 waveforms in units
// of sample ticks (short=4, long=12, sync low=100) and checks vt, D and
// sync_det counts around each frame close.
module tb_decodificador_pt2272;

    localparam int unsigned P = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cod_i;
    logic [15:0] A;
    logic [3:0]  D;
    logic        vt;
    logic        sync_det;

    int n_vec = 0;
    int n_fail = 0;
    int sync_cnt = 0;
    int sync_base = 0;

    decodificador_pt2272 #(
        .PRESC(P),
        .SYNC_MIN(80),
        .VT_TIMEOUT(1100)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cod_i(cod_i),
        .A(A),
        .D(D),
        .vt(vt),
        .sync_det(sync_det)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (sync_det === 1'b1) sync_cnt <= sync_cnt + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic lvl, input int n);
        cod_i = lvl;
        repeat (n * P) @(negedge clk);
    endtask

    // One tri-state symbol starting at width index 'from' (0=H1 .. 3=L2)
    task automatic sym(input logic [1:0] c, input int from);
        int w[4];
        case (c)
            2'b11:   w = '{12, 4, 12, 4};
            2'b01:   w = '{4, 12, 12, 4};
            default: w = '{4, 12, 4, 12};
        endcase
        for (int k = from; k < 4; k++) hold((k % 2) == 0, w[k]);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cod_i = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        sync_base = sync_cnt;
        repeat (2) @(negedge clk);
    endtask

    task automatic preamble();
        hold(1'b1, 4);
        hold(1'b0, 100);
    endtask

    // 12 symbols plus the trailing short high and the first 70 ticks of sync low.
    // glitch_sym / rst_sym assume an address-0 symbol there (short first high).
    task automatic send_frame(input logic [15:0] ac, input logic [3:0] dat,
                              input int glitch_sym, input int rst_sym);
        logic [15:0] as;
        logic [3:0]  ds;
        logic [1:0]  c;
        as = ac;
        ds = dat;
        for (int i = 0; i < 12; i++) begin
            if (i < 8) begin
                c  = as[1:0];
                as = as >> 2;
            end else begin
                c  = {2{ds[3]}};
                ds = ds << 1;
            end
            if (i == glitch_sym) begin
                hold(1'b1, 4); hold(1'b0, 5); hold(1'b1, 1); hold(1'b0, 6);
                hold(1'b1, 4); hold(1'b0, 12);
            end else if (i == rst_sym) begin
                cod_i = 1'b1;
                repeat (2) @(negedge clk);
                reset = 1'b1;
                repeat (2) @(negedge clk);
                reset = 1'b0;
                chk("rst_mid.vt", {31'd0, vt}, 32'd0);
                chk("rst_mid.D", {28'd0, D}, 32'd0);
                repeat (4 * P - 4) @(negedge clk);
                sym(c, 1);
            end else begin
                sym(c, 0);
            end
        end
        hold(1'b1, 4);
        hold(1'b0, 70);
    endtask

    // Checks just before and just after the close point in the trailing sync low
    task automatic frame_close(input string tag, input logic vt_pre,
                               input logic vt_post, input logic [3:0] d_post);
        chk({tag, ".vt_pre"}, {31'd0, vt}, {31'd0, vt_pre});
        hold(1'b0, 20);
        chk({tag, ".vt"}, {31'd0, vt}, {31'd0, vt_post});
        chk({tag, ".D"}, {28'd0, D}, {28'd0, d_post});
        hold(1'b0, 10);
    endtask

    initial begin
        reset = 1'b1;
        cod_i = 1'b0;
        A     = 16'h0000;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        sync_base = sync_cnt;
        repeat (2) @(negedge clk);
        chk("reset.D", {28'd0, D}, 32'd0);
        chk("reset.vt", {31'd0, vt}, 32'd0);
        chk("reset.sync_det", {31'd0, sync_det}, 32'd0);

        // Two matching frames, address 0, data 1010
        A = 16'h0000;
        preamble();
        chk("basic.syncs0", sync_cnt - sync_base, 32'd1);
        send_frame(16'h0000, 4'b1010, -1, -1);
        frame_close("basic.f1", 1'b0, 1'b0, 4'b0000);
        chk("basic.syncs1", sync_cnt - sync_base, 32'd2);
        send_frame(16'h0000, 4'b1010, -1, -1);
        frame_close("basic.f2", 1'b0, 1'b1, 4'b1010);
        chk("basic.syncs2", sync_cnt - sync_base, 32'd3);

        // Address mismatch on every frame
        do_reset();
        A = 16'hFFFF;
        preamble();
        for (int f = 0; f < 3; f++) begin
            send_frame(16'h0000, 4'b1100, -1, -1);
            frame_close("addr_mis", 1'b0, 1'b0, 4'b0000);
        end
        chk("addr_mis.syncs", sync_cnt - sync_base, 32'd4);

        // Mixed 0/1/F address; a mismatching frame invalidates the stored one
        do_reset();
        A = 16'h00C1;
        preamble();
        send_frame(16'h00C1, 4'b0111, -1, -1);
        frame_close("mix.good1", 1'b0, 1'b0, 4'b0000);
        send_frame(16'h00C0, 4'b0111, -1, -1);
        frame_close("mix.bad1", 1'b0, 1'b0, 4'b0000);
        send_frame(16'h00C1, 4'b0111, -1, -1);
        frame_close("mix.good2", 1'b0, 1'b0, 4'b0000);
        send_frame(16'h00C1, 4'b0111, -1, -1);
        frame_close("mix.good3", 1'b0, 1'b1, 4'b0111);
        send_frame(16'h00C0, 4'b1000, -1, -1);
        frame_close("mix.bad2", 1'b1, 1'b1, 4'b0111);

        // Glitch inside symbol 5 of frame 2 aborts it
        do_reset();
        A = 16'h0000;
        preamble();
        send_frame(16'h0000, 4'b0110, -1, -1);
        frame_close("glitch.f1", 1'b0, 1'b0, 4'b0000);
        send_frame(16'h0000, 4'b0110, 4, -1);
        frame_close("glitch.f2", 1'b0, 1'b0, 4'b0000);
        send_frame(16'h0000, 4'b0110, -1, -1);
        frame_close("glitch.f3", 1'b0, 1'b0, 4'b0000);
        send_frame(16'h0000, 4'b0110, -1, -1);
        frame_close("glitch.f4", 1'b0, 1'b1, 4'b0110);

        // Differing data: vt only when two consecutive frames agree
        do_reset();
        A = 16'h0000;
        preamble();
        send_frame(16'h0000, 4'b0001, -1, -1);
        frame_close("seq.f1", 1'b0, 1'b0, 4'b0000);
        send_frame(16'h0000, 4'b0010, -1, -1);
        frame_close("seq.f2", 1'b0, 1'b0, 4'b0000);
        send_frame(16'h0000, 4'b0010, -1, -1);
        frame_close("seq.f3", 1'b0, 1'b1, 4'b0010);

        // Reset inside symbol 8 of the 2nd identical frame, starting from vt=1
        send_frame(16'h0000, 4'b0101, -1, -1);
        frame_close("rst.f1", 1'b1, 1'b1, 4'b0010);
        send_frame(16'h0000, 4'b0101, -1, 7);
        frame_close("rst.f2", 1'b0, 1'b0, 4'b0000);
        send_frame(16'h0000, 4'b0101, -1, -1);
        frame_close("rst.f3", 1'b0, 1'b0, 4'b0000);
        send_frame(16'h0000, 4'b0101, -1, -1);
        frame_close("rst.f4", 1'b0, 1'b1, 4'b0101);

        // vt timeout with the line held low after the last accepted close
        do_reset();
        A = 16'h0000;
        preamble();
        send_frame(16'h0000, 4'b0011, -1, -1);
        frame_close("to.f1", 1'b0, 1'b0, 4'b0000);
        send_frame(16'h0000, 4'b0011, -1, -1);
        frame_close("to.f2", 1'b0, 1'b1, 4'b0011);
        hold(1'b0, 1070);
        chk("to.vt_before", {31'd0, vt}, 32'd1);
        chk("to.D_before", {28'd0, D}, 32'h3);
        hold(1'b0, 20);
        chk("to.vt_after", {31'd0, vt}, 32'd0);
`ifdef DECOD_MOMENTARY_EN
        chk("to.D_after", {28'd0, D}, 32'h0);
`else
        chk("to.D_after", {28'd0, D}, 32'h3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
